// File: rtl/traffic_intersection_ctrl_if.sv
// Command/event bus of the traffic intersection controller.
// The master drives override commands and receives lamp-state change
// reports. The slave is the controller.
interface traffic_intersection_ctrl_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic [1:0] evt_dir;

  modport master (
    output cmd_valid, cmd_data,
    input  evt_valid, evt_code, evt_dir
  );

  modport slave (
    input  cmd_valid, cmd_data,
    output evt_valid, evt_code, evt_dir
  );
endinterface

// File: rtl/traffic_intersection_ctrl.sv
// Traffic intersection controller for 2..4 approaches.
// Approaches are served round-robin through GREEN -> YELLOW -> ALLRED.
// A one-second prescaler times every phase.
// Pending demand from another approach can end a green early once the
// minimum green time has elapsed.
// ASCII override commands are accepted on the bus:
//   'R' all-red hold, 'F' flash, 'N' end green now, 'X' resume.
// Each lamp-state entry is reported on the bus as a one-cycle event.
module traffic_intersection_ctrl #(
  parameter int TICKS_PER_SEC = 12000000,
  parameter int N_DIR         = 2,
  parameter int GREEN_S       = 4,
  parameter int MIN_GREEN_S   = 2,
  parameter int YELLOW_S      = 2,
  parameter int ALLRED_S      = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_DIR-1:0]             req,
  traffic_intersection_ctrl_if.slave   bus,
  output logic [N_DIR-1:0]             red,
  output logic [N_DIR-1:0]             yellow,
  output logic [N_DIR-1:0]             green,
  output logic [1:0]                   cur_dir,
  output logic [1:0]                   mode
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [4:0]       GREEN_T   = 5'(GREEN_S);
  localparam logic [4:0]       MIN_T     = 5'(MIN_GREEN_S);
  localparam logic [4:0]       YELLOW_T  = 5'(YELLOW_S);
  localparam logic [4:0]       ALLRED_T  = 5'(ALLRED_S);
  localparam logic [N_DIR-1:0] DIR1      = N_DIR'(1);
  localparam logic [1:0]       LAST_DIR  = 2'(N_DIR - 1);

  localparam logic [7:0] CH_G = "G";
  localparam logic [7:0] CH_Y = "Y";
  localparam logic [7:0] CH_A = "r";
  localparam logic [7:0] CH_R = "R";
  localparam logic [7:0] CH_F = "F";
  localparam logic [7:0] CH_N = "N";
  localparam logic [7:0] CH_X = "X";

  typedef enum logic [2:0] {
    ST_GREEN,
    ST_YELLOW,
    ST_ALLRED,
    ST_HOLD,
    ST_FLASH
  } state_e;

  state_e           st_q, st_d;
  logic [1:0]       dir_q, dir_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [3:0]       timer_q, timer_d;
  logic             flash_q, flash_d;
  logic [N_DIR-1:0] dem_q, dem_d;
  logic [N_DIR-1:0] red_q, red_d;
  logic [N_DIR-1:0] yellow_q, yellow_d;
  logic [N_DIR-1:0] green_q, green_d;
  logic [1:0]       mode_q, mode_d;
  logic             evt_valid_q, evt_valid_d;
  logic [7:0]       evt_code_q, evt_code_d;
  logic [1:0]       evt_dir_q, evt_dir_d;

  logic             sec_tick;
  logic [4:0]       timer_p1;
  logic [1:0]       dir_next;
  logic             other_dem;
  logic             entry;
  logic [N_DIR-1:0] served;

  // Next-state logic: timed phase changes first, then commands override them.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default value first.
    // Without the defaults, a path that skips an assignment infers a latch.
    sec_tick  = (presc_q == PRESC_MAX);
    timer_p1  = {1'b0, timer_q} + 5'd1;
    dir_next  = (dir_q == LAST_DIR) ? 2'd0 : dir_q + 2'd1;
    other_dem = |(dem_q & ~(DIR1 << dir_q));
    st_d      = st_q;
    dir_d     = dir_q;
    presc_d   = sec_tick ? '0 : presc_q + PW'(1);
    timer_d   = sec_tick ? timer_q + 4'd1 : timer_q;
    flash_d   = flash_q;

    unique case (st_q)
      ST_GREEN: begin
        if (sec_tick && (timer_p1 == GREEN_T || (timer_p1 >= MIN_T && other_dem)))
          st_d = ST_YELLOW;
      end
      ST_YELLOW: begin
        if (sec_tick && timer_p1 == YELLOW_T)
          st_d = ST_ALLRED;
      end
      ST_ALLRED: begin
        if (sec_tick && timer_p1 == ALLRED_T) begin
          st_d  = ST_GREEN;
          dir_d = dir_next;
        end
      end
      ST_HOLD: begin
        presc_d = presc_q;
        timer_d = timer_q;
      end
      ST_FLASH: begin
        if (sec_tick)
          flash_d = ~flash_q;
      end
      default: st_d = ST_GREEN;
    endcase

    // A command wins over a timed transition in the same cycle.
    if (bus.cmd_valid) begin
      unique case (bus.cmd_data)
        CH_R: if (st_q != ST_HOLD) begin
          st_d  = ST_HOLD;
          dir_d = dir_q;
        end
        CH_F: if (st_q != ST_FLASH) begin
          st_d  = ST_FLASH;
          dir_d = dir_q;
        end
        CH_N: if (st_q == ST_GREEN) begin
          st_d  = ST_YELLOW;
          dir_d = dir_q;
        end
        CH_X: if (st_q == ST_HOLD || st_q == ST_FLASH) begin
          st_d    = ST_ALLRED;
          dir_d   = dir_q;
          presc_d = '0;
        end
        default: ;
      endcase
    end

    // Each state entry restarts the seconds timer.
    entry = (st_d != st_q);
    if (entry) begin
      timer_d = '0;
      if (st_d == ST_FLASH)
        flash_d = 1'b1;
    end

    // A demand set wins over a clear in the same cycle.
    for (int j = 0; j < N_DIR; j++) begin
      dem_d[j] = req[j] |
                 (dem_q[j] & ~(entry && st_d == ST_GREEN && dir_d == 2'(j)));
    end

    unique case (st_d)
      ST_HOLD:  mode_d = 2'b01;
      ST_FLASH: mode_d = 2'b10;
      default:  mode_d = 2'b00;
    endcase

    evt_valid_d = entry;
    evt_dir_d   = dir_d;
    unique case (st_d)
      ST_GREEN:  evt_code_d = CH_G;
      ST_YELLOW: evt_code_d = CH_Y;
      ST_ALLRED: evt_code_d = CH_A;
      ST_HOLD:   evt_code_d = CH_R;
      default:   evt_code_d = CH_F;
    endcase
  end

  // Lamp decode from the registered state, so the lamps follow one edge later.
  always_comb begin
    served   = DIR1 << dir_q;
    red_d    = '1;
    yellow_d = '0;
    green_d  = '0;
    unique case (st_q)
      ST_GREEN: begin
        red_d   = ~served;
        green_d = served;
      end
      ST_YELLOW: begin
        red_d    = ~served;
        yellow_d = served;
      end
      ST_FLASH: begin
        red_d    = '0;
        yellow_d = {N_DIR{flash_q}};
      end
      default: ;
    endcase
  end

  // State, timers, demand latches and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every flop sampling the
    // pre-edge values, whatever order the statements appear in.
    if (!rst_n) begin
      st_q        <= ST_GREEN;
      dir_q       <= 2'd0;
      presc_q     <= '0;
      timer_q     <= '0;
      flash_q     <= 1'b0;
      dem_q       <= '0;
      red_q       <= ~DIR1;
      yellow_q    <= '0;
      green_q     <= DIR1;
      mode_q      <= 2'b00;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
      evt_dir_q   <= 2'd0;
    end else begin
      st_q        <= st_d;
      dir_q       <= dir_d;
      presc_q     <= presc_d;
      timer_q     <= timer_d;
      flash_q     <= flash_d;
      dem_q       <= dem_d;
      red_q       <= red_d;
      yellow_q    <= yellow_d;
      green_q     <= green_d;
      mode_q      <= mode_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_dir_q   <= evt_dir_d;
    end
  end

  assign red           = red_q;
  assign yellow        = yellow_q;
  assign green         = green_q;
  assign cur_dir       = dir_q;
  assign mode          = mode_q;
  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_code  = evt_code_q;
  assign bus.evt_dir   = evt_dir_q;

endmodule
